// File: rtl/cis_exp_pkg.sv
// ============================================================================
// Module      : cis_exp_pkg
// Description : Shared types, constants and helpers for the CIS exposure sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cis_exp_pkg;

   typedef enum logic {
      MODE_GRAY  = 1'b0,
      MODE_COLOR = 1'b1
   } mode_e;

   localparam int LEAD_DEFAULT = 3;

   // Channel-index width; never narrower than one bit.
   function automatic int ch_idx_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

`default_nettype wire

// File: rtl/cis_exposure_seq_if.sv
// ============================================================================
// Module      : cis_exposure_seq_if
// Description : Line-control inputs and LED-driver outputs of the exposure sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface cis_exposure_seq_if
   import cis_exp_pkg::*;
#(
   parameter int NCH = 3,
   parameter int CW  = 16
);
   localparam int CHW = ch_idx_w(NCH);

   logic              start;
   logic              color_mode;
   logic              si;
   logic [NCH-1:0]    ch_en;
   logic [NCH*CW-1:0] exp_time;
   logic [NCH-1:0]    led_en;
   logic              led_oe_n;
   logic [CHW-1:0]    line_ch;
   logic              line_done;
   logic              overrun;

   modport master (
      output start, color_mode, si, ch_en, exp_time,
      input  led_en, led_oe_n, line_ch, line_done, overrun
   );

   modport slave (
      input  start, color_mode, si, ch_en, exp_time,
      output led_en, led_oe_n, line_ch, line_done, overrun
   );

endinterface

`default_nettype wire

// File: rtl/cis_exp_window.sv
// ============================================================================
// Module      : cis_exp_window
// Description : Registered LED window: high one cycle after cnt enters [off, off+len).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cis_exp_window #(
   parameter int W = 18
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr_i,
   input  logic         active_i,
   input  logic [W-1:0] cnt_i,
   input  logic [W-1:0] off_i,
   input  logic [W-1:0] len_i,
   output logic         en_o
);

   logic en_q;
   logic en_d;

   always_comb begin
      en_d = !clr_i && active_i && (cnt_i >= off_i) && (cnt_i < off_i + len_i);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         en_q <= 1'b0;
      end else begin
         en_q <= en_d;
      end
   end

   assign en_o = en_q;

endmodule

`default_nettype wire

// File: rtl/cis_exposure_seq.sv
// ============================================================================
// Module      : cis_exposure_seq
// Description : CIS LED exposure sequencer (colour rotation / gray all-channel).
//               Define CIS_EXP_STATUS_EN to build the sticky overrun flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cis_exposure_seq
   import cis_exp_pkg::*;
#(
   parameter int NCH  = 3,
   parameter int CW   = 16,
   parameter int LEAD = LEAD_DEFAULT
) (
   input logic                clk,
   input logic                rst_n,
   cis_exposure_seq_if.slave  bus
);

   localparam int              CHW    = ch_idx_w(NCH);
   localparam int              XW     = CW + 2;
   localparam logic [XW-1:0]   LEAD_X = XW'(LEAD);

   logic              si_meta_q, si_d0_q, si_d1_q;
   logic              si_rise;
   logic              active_q, active_d;
   logic [XW-1:0]     cnt_q, cnt_d;
   logic [CHW-1:0]    ptr_q, ptr_d;
   logic [CHW-1:0]    lch_q, lch_d;
   logic [NCH*CW-1:0] exp_sh_q, exp_sh_d;
   logic [NCH-1:0]    en_sh_q, en_sh_d;
   mode_e             mode_sh_q, mode_sh_d;
   logic              oe_n_q, oe_n_d;
   logic              done_q, done_d;
   logic              win_clr;
   logic [XW-1:0]     t_eff   [NCH];
   logic [XW-1:0]     win_off [NCH];
   logic [XW-1:0]     win_len [NCH];
   logic [XW-1:0]     gray_sum, color_len, line_end;
   logic [NCH-1:0]    led_en_w;

   function automatic logic [CHW-1:0] lowest_en(input logic [NCH-1:0] en);
      logic [CHW-1:0] r;
      r = '0;
      for (int k = NCH - 1; k >= 0; k--) begin
         if (en[k]) r = CHW'(k);
      end
      return r;
   endfunction

   // Next enabled channel after p, wrapping; p itself if no other is enabled.
   function automatic logic [CHW-1:0] next_en(input logic [CHW-1:0] p, input logic [NCH-1:0] en);
      logic [CHW-1:0] r;
      int             idx;
      r = p;
      for (int i = NCH - 1; i >= 1; i--) begin
         idx = (int'(p) + i) % NCH;
         if (en[idx]) r = CHW'(idx);
      end
      return r;
   endfunction

   assign si_rise = si_d0_q & ~si_d1_q;

   // Window placement from the shadowed line parameters.
   always_comb begin
      gray_sum  = '0;
      color_len = '0;
      for (int k = 0; k < NCH; k++) begin
         t_eff[k] = en_sh_q[k] ? XW'(exp_sh_q[k*CW +: CW]) : '0;
         if (mode_sh_q == MODE_COLOR) begin
            win_off[k] = LEAD_X;
            win_len[k] = (lch_q == CHW'(k)) ? t_eff[k] : '0;
         end else begin
            win_off[k] = LEAD_X + gray_sum;
            win_len[k] = t_eff[k];
         end
         if (lch_q == CHW'(k)) color_len = t_eff[k];
         gray_sum = gray_sum + t_eff[k];
      end
      line_end = LEAD_X + ((mode_sh_q == MODE_COLOR) ? color_len : gray_sum);
   end

   always_comb begin
      active_d  = active_q;
      cnt_d     = cnt_q;
      ptr_d     = ptr_q;
      lch_d     = lch_q;
      exp_sh_d  = exp_sh_q;
      en_sh_d   = en_sh_q;
      mode_sh_d = mode_sh_q;
      oe_n_d    = 1'b1;
      done_d    = 1'b0;
      win_clr   = 1'b0;
      if (bus.start) begin
         active_d = 1'b0;
         cnt_d    = '0;
         ptr_d    = lowest_en(bus.ch_en);
         lch_d    = '0;
         win_clr  = 1'b1;
      end else if (si_rise) begin
         // A new line (or a restart) drops whatever the previous line drove.
         active_d  = 1'b1;
         cnt_d     = '0;
         exp_sh_d  = bus.exp_time;
         en_sh_d   = bus.ch_en;
         mode_sh_d = mode_e'(bus.color_mode);
         win_clr   = 1'b1;
         if (bus.color_mode == MODE_COLOR) begin
            lch_d = ptr_q;
            ptr_d = next_en(ptr_q, bus.ch_en);
         end else begin
            lch_d = '0;
         end
      end else if (active_q) begin
         if (cnt_q == line_end) begin
            active_d = 1'b0;
            done_d   = 1'b1;
         end else begin
            cnt_d  = cnt_q + 1'b1;
            oe_n_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         si_meta_q <= 1'b0;
         si_d0_q   <= 1'b0;
         si_d1_q   <= 1'b0;
         active_q  <= 1'b0;
         cnt_q     <= '0;
         ptr_q     <= '0;
         lch_q     <= '0;
         exp_sh_q  <= '0;
         en_sh_q   <= '0;
         mode_sh_q <= MODE_GRAY;
         oe_n_q    <= 1'b1;
         done_q    <= 1'b0;
      end else begin
         si_meta_q <= bus.si;
         si_d0_q   <= si_meta_q;
         si_d1_q   <= si_d0_q;
         active_q  <= active_d;
         cnt_q     <= cnt_d;
         ptr_q     <= ptr_d;
         lch_q     <= lch_d;
         exp_sh_q  <= exp_sh_d;
         en_sh_q   <= en_sh_d;
         mode_sh_q <= mode_sh_d;
         oe_n_q    <= oe_n_d;
         done_q    <= done_d;
      end
   end

   for (genvar k = 0; k < NCH; k++) begin : g_win
      cis_exp_window #(
         .W (XW)
      ) u_win (
         .clk      (clk),
         .rst_n    (rst_n),
         .clr_i    (win_clr),
         .active_i (active_q),
         .cnt_i    (cnt_q),
         .off_i    (win_off[k]),
         .len_i    (win_len[k]),
         .en_o     (led_en_w[k])
      );
   end

`ifdef CIS_EXP_STATUS_EN
   logic ovr_q;

   always_ff @(posedge clk) begin
      if (!rst_n || bus.start) begin
         ovr_q <= 1'b0;
      end else if (si_rise && active_q) begin
         ovr_q <= 1'b1;
      end
   end

   assign bus.overrun = ovr_q;
`else
   assign bus.overrun = 1'b0;
`endif

   assign bus.led_en    = led_en_w;
   assign bus.led_oe_n  = oe_n_q;
   assign bus.line_ch   = lch_q;
   assign bus.line_done = done_q;

endmodule

`default_nettype wire
